// File: rtl/respondedor_es_pkg.sv
// Shared constants for the I/O responder: register offsets, CTRL/PEND bit
// positions and the interrupt codes handed to the processor core.
package es_pkg;

  localparam logic [2:0] OFF_SAL0    = 3'd0;
  localparam logic [2:0] OFF_SAL1    = 3'd1;
  localparam logic [2:0] OFF_ENT0    = 3'd2;
  localparam logic [2:0] OFF_ENT1    = 3'd3;
  localparam logic [2:0] OFF_RECARGA = 3'd4;
  localparam logic [2:0] OFF_CUENTA  = 3'd5;
  localparam logic [2:0] OFF_CTRL    = 3'd6;
  localparam logic [2:0] OFF_PEND    = 3'd7;

  localparam int CTRL_RUN = 0;
  localparam int CTRL_TIE = 1;
  localparam int CTRL_IE0 = 2;
  localparam int CTRL_IE1 = 3;

  localparam int PEND_TIM = 0;
  localparam int PEND_E0  = 1;
  localparam int PEND_E1  = 2;

  localparam logic [2:0] IRQ_NINGUNA = 3'b000;
  localparam logic [2:0] IRQ_TIMER   = 3'b001;
  localparam logic [2:0] IRQ_ENT0    = 3'b010;
  localparam logic [2:0] IRQ_ENT1    = 3'b011;

endpackage

// File: rtl/respondedor_es_sincronizador.sv
// Two-flop synchronizer bringing an asynchronous device port into clk.
module sincronizador #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/respondedor_es.sv
// I/O bus responder: output/input ports, prescaled down-counter timer and
// a registered fixed-priority interrupt code for the core.
module respondedor_es
  import es_pkg::*;
#(
  parameter logic [7:0] BASE     = 8'h80,
  parameter int         PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_wishbone,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] dir,
  input  logic [7:0]  datos_cpu,
  output logic [7:0]  datos_es,
  output logic [2:0]  interrupciones,
  input  logic [7:0]  ent0,
  input  logic [7:0]  ent1,
  output logic [7:0]  sal0,
  output logic [7:0]  sal1
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic          sel;
  logic [2:0]    off;
  logic          wrEn;
  logic [7:0]    sal0Reg, sal1Reg, recarga, cuenta;
  logic [3:0]    ctrl;
  logic [2:0]    pend, pendSet, pendClr;
  logic [PW-1:0] presc;
  logic [7:0]    ent0Sync, ent1Sync, ent0Prev, ent1Prev;
  logic          tick, startLoad;
  logic [2:0]    irqNext;

  sincronizador #(.W(8)) uSync0 (.clk(clk), .reset(reset), .d(ent0), .q(ent0Sync));
  sincronizador #(.W(8)) uSync1 (.clk(clk), .reset(reset), .d(ent1), .q(ent1Sync));

  assign sel  = enable_wishbone && (dir[15:8] == BASE) && (dir[7:3] == 5'd0);
  assign off  = dir[2:0];
  assign wrEn = sel && wr;

  // Reload on RECARGA writes (with the new value) or on a 0->1 run edge.
  assign startLoad = (wrEn && off == OFF_RECARGA) ||
                     (wrEn && off == OFF_CTRL && datos_cpu[CTRL_RUN] && !ctrl[CTRL_RUN]);
  assign tick      = ctrl[CTRL_RUN] && (presc == PRESC_MAX);

  always_comb begin
    pendSet           = '0;
    pendSet[PEND_TIM] = tick && (cuenta == 8'd0);
    pendSet[PEND_E0]  = (ent0Sync != ent0Prev);
    pendSet[PEND_E1]  = (ent1Sync != ent1Prev);
    pendClr           = (wrEn && off == OFF_PEND) ? datos_cpu[2:0] : 3'b000;
  end

  always_comb begin
    irqNext = IRQ_NINGUNA;
    if (pend[PEND_TIM] && ctrl[CTRL_TIE])     irqNext = IRQ_TIMER;
    else if (pend[PEND_E0] && ctrl[CTRL_IE0]) irqNext = IRQ_ENT0;
    else if (pend[PEND_E1] && ctrl[CTRL_IE1]) irqNext = IRQ_ENT1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sal0Reg        <= '0;
      sal1Reg        <= '0;
      recarga        <= '0;
      cuenta         <= '0;
      ctrl           <= '0;
      pend           <= '0;
      presc          <= '0;
      ent0Prev       <= '0;
      ent1Prev       <= '0;
      interrupciones <= IRQ_NINGUNA;
    end else begin
      if (wrEn && off == OFF_SAL0)    sal0Reg <= datos_cpu;
      if (wrEn && off == OFF_SAL1)    sal1Reg <= datos_cpu;
      if (wrEn && off == OFF_RECARGA) recarga <= datos_cpu;
      if (wrEn && off == OFF_CTRL)    ctrl    <= datos_cpu[3:0];

      // Set beats write-1-clear when both hit the same bit.
      pend <= (pend & ~pendClr) | pendSet;

      if (startLoad) begin
        cuenta <= (wrEn && off == OFF_RECARGA) ? datos_cpu : recarga;
        presc  <= '0;
      end else if (!ctrl[CTRL_RUN]) begin
        presc <= '0;
      end else if (tick) begin
        presc  <= '0;
        cuenta <= (cuenta == 8'd0) ? recarga : cuenta - 8'd1;
      end else begin
        presc <= presc + PW'(1);
      end

      ent0Prev       <= ent0Sync;
      ent1Prev       <= ent1Sync;
      interrupciones <= irqNext;
    end
  end

  always_comb begin
    datos_es = 8'h00;
    if (sel && rd) begin
      case (off)
        OFF_SAL0:    datos_es = sal0Reg;
        OFF_SAL1:    datos_es = sal1Reg;
        OFF_ENT0:    datos_es = ent0Sync;
        OFF_ENT1:    datos_es = ent1Sync;
        OFF_RECARGA: datos_es = recarga;
        OFF_CUENTA:  datos_es = cuenta;
        OFF_CTRL:    datos_es = {4'b0000, ctrl};
        OFF_PEND:    datos_es = {5'b00000, pend};
        default:     datos_es = 8'h00;
      endcase
    end
  end

  assign sal0 = sal0Reg;
  assign sal1 = sal1Reg;

endmodule

// File: tb/tb_respondedor_es.sv
// Directed bench for respondedor_es with hand-computed expectations.
module tb_respondedor_es;

  logic        clk = 1'b0;
  logic        reset;
  logic        enableWishbone;
  logic        rd;
  logic        wr;
  logic [15:0] dir;
  logic [7:0]  datosCpu;
  logic [7:0]  datosEs;
  logic [2:0]  interrupciones;
  logic [7:0]  ent0;
  logic [7:0]  ent1;
  logic [7:0]  sal0;
  logic [7:0]  sal1;

  int vectors = 0;
  int miscompares = 0;

  respondedor_es #(.BASE(8'h80), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .enable_wishbone(enableWishbone), .rd(rd), .wr(wr),
    .dir(dir), .datos_cpu(datosCpu), .datos_es(datosEs), .interrupciones(interrupciones),
    .ent0(ent0), .ent1(ent1), .sal0(sal0), .sal1(sal1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [7:0] d);
    enableWishbone = 1'b1; wr = 1'b1; dir = a; datosCpu = d;
    step();
    enableWishbone = 1'b0; wr = 1'b0; dir = 16'h0000; datosCpu = 8'h00;
  endtask

  task automatic readCheck(input string tag, input logic [2:0] o, input logic [7:0] exp);
    enableWishbone = 1'b1; rd = 1'b1; dir = {13'h1000, o};
    #1;
    check(tag, datosEs, exp);
    enableWishbone = 1'b0; rd = 1'b0; dir = 16'h0000;
  endtask

  initial begin
    reset = 1'b1; enableWishbone = 1'b0; rd = 1'b0; wr = 1'b0;
    dir = 16'h0000; datosCpu = 8'h00; ent0 = 8'h00; ent1 = 8'h00;
    steps(2);
    reset = 1'b0;
    step();

    // Reset state
    for (int o = 0; o < 8; o++) readCheck($sformatf("rst_rd%0d", o), 3'(o), 8'h00);
    check("rst_irq", {5'b0, interrupciones}, 8'h00);
    check("rst_sal0", sal0, 8'h00);

    // Output ports and select decoding
    busWrite(16'h8000, 8'hA5);
    check("sal0_wr", sal0, 8'hA5);
    busWrite(16'h8001, 8'h3C);
    check("sal1_wr", sal1, 8'h3C);
    readCheck("sal0_rd", 3'd0, 8'hA5);
    readCheck("sal1_rd", 3'd1, 8'h3C);
    busWrite(16'h8100, 8'h11);
    check("base_miss_sal0", sal0, 8'hA5);
    busWrite(16'h8109, 8'h22);
    check("base_miss_sal1", sal1, 8'h3C);
    busWrite(16'h8008, 8'h33);
    check("hi_off_miss", sal0, 8'hA5);
    enableWishbone = 1'b0; wr = 1'b1; dir = 16'h8001; datosCpu = 8'h44;
    step();
    wr = 1'b0; dir = 16'h0000;
    check("no_enable", sal1, 8'h3C);
    enableWishbone = 1'b0; rd = 1'b1; dir = 16'h8000; #1;
    check("rd_no_enable", datosEs, 8'h00);
    rd = 1'b0;
    busWrite(16'h8002, 8'h5A);
    readCheck("ro_ent0", 3'd2, 8'h00);

    // Timer: RECARGA=3, PRESCALE=4 -> fires 16 edges after run
    busWrite(16'h8004, 8'h03);
    readCheck("cuenta_load", 3'd5, 8'h03);
    busWrite(16'h8006, 8'h03);               // edge E0
    readCheck("ctrl_rd", 3'd6, 8'h03);
    steps(15);                               // E0+15
    readCheck("pend_pre", 3'd7, 8'h00);
    readCheck("cuenta_zero", 3'd5, 8'h00);
    check("irq_pre", {5'b0, interrupciones}, 8'h00);
    step();                                  // E0+16
    readCheck("pend_fire", 3'd7, 8'h01);
    readCheck("cuenta_reload", 3'd5, 8'h03);
    check("irq_lag", {5'b0, interrupciones}, 8'h00);
    step();                                  // E0+17
    check("irq_timer", {5'b0, interrupciones}, 8'h01);
    busWrite(16'h8007, 8'h01);               // clear at E0+18
    readCheck("pend_clr", 3'd7, 8'h00);
    step();                                  // E0+19
    check("irq_clr", {5'b0, interrupciones}, 8'h00);
    steps(12);                               // E0+31
    readCheck("pend_pre2", 3'd7, 8'h00);
    step();                                  // E0+32
    readCheck("pend_fire2", 3'd7, 8'h01);
    step();                                  // E0+33
    check("irq_timer2", {5'b0, interrupciones}, 8'h01);
    steps(14);                               // E0+47
    readCheck("cuenta_zero2", 3'd5, 8'h00);
    busWrite(16'h8007, 8'h01);               // clear on the firing edge E0+48
    readCheck("set_wins", 3'd7, 8'h01);
    check("irq_set_wins", {5'b0, interrupciones}, 8'h01);
    busWrite(16'h8006, 8'h00);
    busWrite(16'h8007, 8'h07);
    step();
    check("irq_stop", {5'b0, interrupciones}, 8'h00);
    readCheck("pend_stop", 3'd7, 8'h00);

    // Input change interrupts
    busWrite(16'h8006, 8'h0C);
    ent0 = 8'hFF; ent1 = 8'h01;
    step();                                  // edge 1
    readCheck("ent0_e1", 3'd2, 8'h00);
    step();                                  // edge 2
    readCheck("ent0_e2", 3'd2, 8'hFF);
    readCheck("ent1_e2", 3'd3, 8'h01);
    readCheck("pend_e2", 3'd7, 8'h00);
    step();                                  // edge 3
    readCheck("pend_ent", 3'd7, 8'h06);
    check("irq_ent_lag", {5'b0, interrupciones}, 8'h00);
    step();                                  // edge 4
    check("irq_ent0", {5'b0, interrupciones}, 8'h02);
    busWrite(16'h8007, 8'h02);
    readCheck("pend_clr1", 3'd7, 8'h04);
    step();
    check("irq_ent1", {5'b0, interrupciones}, 8'h03);
    busWrite(16'h8007, 8'h04);
    step();
    check("irq_none", {5'b0, interrupciones}, 8'h00);
    readCheck("ctrl_hi0", 3'd6, 8'h0C);

    // Reset mid-count and mid-access
    busWrite(16'h8004, 8'h02);
    busWrite(16'h8006, 8'h0F);               // edge R0
    ent0 = 8'h00; ent1 = 8'h00;
    steps(12);                               // R0+12
    readCheck("pend_all", 3'd7, 8'h07);
    readCheck("cuenta_two", 3'd5, 8'h02);
    check("irq_prio", {5'b0, interrupciones}, 8'h02);
    reset = 1'b1; enableWishbone = 1'b1; wr = 1'b1; dir = 16'h8000; datosCpu = 8'h77;
    step();
    reset = 1'b0; enableWishbone = 1'b0; wr = 1'b0; dir = 16'h0000; datosCpu = 8'h00;
    check("rst2_sal0", sal0, 8'h00);
    check("rst2_sal1", sal1, 8'h00);
    check("rst2_irq", {5'b0, interrupciones}, 8'h00);
    for (int o = 0; o < 8; o++) readCheck($sformatf("rst2_rd%0d", o), 3'(o), 8'h00);
    steps(5);
    readCheck("rst2_cuenta_held", 3'd5, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
